keypad_debounce_decode: RTL and testbench
=========================================

KEYPAD_DEBOUNCE_DECODE -- requirements
Module: keypad_debounce_decode

Interface
REQ-001 Parameter DB_CYCLES, default 50000: count of consecutive stable synchronized cycles needed to accept a press or a release; legal range 2..65535.
REQ-002 Parameter SCAN_DIV, default 1000: clk cycles per row dwell in SCAN; legal minimum 4.
REQ-003 clk  input  1  block clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 cols  input  4  raw asynchronous keypad column lines; 1 = key pressed in the active row.
REQ-006 rows  input  4  one-hot active-row vector from the upstream row sweeper; bit i = row i.
REQ-007 advance  output  1  one-cycle pulse that steps the row sweeper to the next row.
REQ-008 key_code  output  4  code of the last accepted key, equal to 4*row_index + col_index.
REQ-009 key_valid  output  1  one-cycle pulse marking a newly accepted key.
REQ-010 key_held  output  1  high while an accepted key is still held or releasing.

Function
REQ-011 cols shall pass through a 2-flop synchronizer; all other logic uses only the synchronized value scols.
REQ-012 The FSM shall have exactly four states: SCAN, DEBOUNCE, HELD and RELEASE.
REQ-013 In SCAN, a dwell counter shall count 0..SCAN_DIV-1 and then wrap to 0.
REQ-014 In SCAN, advance shall be asserted for one cycle when the dwell counter equals SCAN_DIV-1 and scols == 0.
REQ-015 In SCAN, any scols bit may be sampled only while the dwell counter is >= 3, so the synchronizer settles after a row change.
REQ-016 When a sampled scols is nonzero in SCAN:
- capture row index = position of the set bit of rows, and col index = lowest set bit of scols;
- clear the stable counter;
- enter DEBOUNCE;
- do not pulse advance that cycle.
REQ-017 If rows is not one-hot at capture, the capture shall be ignored and the FSM shall stay in SCAN.
REQ-018 In DEBOUNCE, the stable counter shall increment each cycle the captured column bit of scols is 1.
REQ-019 In DEBOUNCE, if the captured column bit of scols is 0, the FSM shall return to SCAN with the dwell counter cleared and no output change.
REQ-020 When the stable counter reaches DB_CYCLES-1 with the column still high:
- key_code = 4*row + col;
- key_valid pulses for exactly that one cycle;
- key_held goes to 1;
- the FSM enters HELD.
REQ-021 In HELD, the FSM shall stay while the captured column is 1, and on a 0 it shall clear the stable counter and enter RELEASE.
REQ-022 In RELEASE, the stable counter shall count consecutive cycles with the captured column at 0.
REQ-023 In RELEASE, a 1 on the captured column shall return the FSM to HELD with no new key_valid pulse.
REQ-024 When the RELEASE count reaches DB_CYCLES-1, key_held shall go to 0, the FSM shall enter SCAN with the dwell counter cleared, and key_code shall hold its value.
REQ-025 advance shall be 0 in every state other than SCAN, so the row stays frozen from capture until release completes.
REQ-026 A second column pressed in the same row while in DEBOUNCE, HELD or RELEASE shall be ignored; only the captured column is tracked.
REQ-027 Counters shall be sized to $clog2 of their maximum value and shall never wrap outside the rules above.

Reset
REQ-028 While reset is high at a clock edge, every register shall take its reset value:
- FSM = SCAN;
- dwell and stable counters = 0;
- synchronizer flops = 0;
- key_code = 4'h0;
- key_valid = advance = key_held = 0.
REQ-029 Reset asserted in any state, including mid-debounce or held, shall abort the operation, produce no key_valid, and take effect at the next edge.

Verification (DB_CYCLES=8, SCAN_DIV=4)
REQ-030 Idle, cols=0 -> advance pulses once every 4 cycles and key_valid stays 0.
REQ-031 rows=4'b0100 and cols=4'b0010 held for 30 cycles -> exactly one key_valid with key_code=4'h9, key_held=1, and no advance while held.
REQ-032 Press for 5 cycles, then 0 -> no key_valid; return to SCAN with advance resuming.
REQ-033 Accepted key, release for 3 cycles, re-press, then release for 10 cycles -> a single key_valid total, key_held falls after 8 stable-low cycles, and scanning resumes.
REQ-034 rows=4'b0001 and cols=4'b1010 -> key_code=4'h1 (lowest column wins).
REQ-035 Reset pulsed during DEBOUNCE, and separately during HELD -> all outputs 0 on the next cycle, no key_valid, and scanning restarts.

Source files
------------

// File: rtl/keypad_debounce_decode.sv
// Keypad front end: synchronizes the column lines, holds the row sweep while a key
// is debounced, and reports one code per accepted press with a held flag until release.
module keypad_debounce_decode #(
    parameter int DB_CYCLES = 50000,
    parameter int SCAN_DIV  = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cols,
    input  logic [3:0] rows,
    output logic       advance,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int DW_W = $clog2(SCAN_DIV);
    localparam int ST_W = $clog2(DB_CYCLES);
    localparam logic [DW_W-1:0] DWELL_LAST   = DW_W'(SCAN_DIV - 1);
    localparam logic [DW_W-1:0] DWELL_SAMPLE = DW_W'(3);
    localparam logic [ST_W-1:0] STABLE_LAST  = ST_W'(DB_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HELD     = 2'd2,
        ST_RELEASE  = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [3:0]      r_sync1;
    logic [3:0]      r_scols;
    logic [DW_W-1:0] r_dwell;
    logic [DW_W-1:0] w_dwell_nxt;
    logic [ST_W-1:0] r_stable;
    logic [ST_W-1:0] w_stable_nxt;
    logic [1:0]      r_row;
    logic [1:0]      w_row_nxt;
    logic [1:0]      r_col;
    logic [1:0]      w_col_nxt;
    logic [3:0]      r_key_code;
    logic [3:0]      w_code_nxt;
    logic            r_key_valid;
    logic            w_valid_nxt;
    logic            r_advance;
    logic            w_adv_nxt;
    logic            r_key_held;
    logic            w_held_nxt;

    logic            w_row_ok;
    logic [1:0]      w_row_idx;
    logic [1:0]      w_col_idx;
    logic            w_sample;
    logic            w_tracked;

    assign w_sample  = (r_dwell >= DWELL_SAMPLE) && (r_scols != 4'h0);
    assign w_tracked = r_scols[r_col];

    // Row index from the one-hot row vector; anything else is flagged as unusable.
    always_comb begin
        w_row_ok  = 1'b1;
        w_row_idx = 2'd0;
        case (rows)
            4'b0001: w_row_idx = 2'd0;
            4'b0010: w_row_idx = 2'd1;
            4'b0100: w_row_idx = 2'd2;
            4'b1000: w_row_idx = 2'd3;
            default: begin
                w_row_ok  = 1'b0;
                w_row_idx = 2'd0;
            end
        endcase
    end

    // Lowest pressed column wins when several are active.
    always_comb begin
        w_col_idx = 2'd3;
        if (r_scols[0]) begin
            w_col_idx = 2'd0;
        end else if (r_scols[1]) begin
            w_col_idx = 2'd1;
        end else if (r_scols[2]) begin
            w_col_idx = 2'd2;
        end else begin
            w_col_idx = 2'd3;
        end
    end

    // Next-state and next-output logic for the scan/debounce/held/release FSM.
    always_comb begin
        w_state_nxt  = r_state;
        w_dwell_nxt  = r_dwell;
        w_stable_nxt = r_stable;
        w_row_nxt    = r_row;
        w_col_nxt    = r_col;
        w_code_nxt   = r_key_code;
        w_valid_nxt  = 1'b0;
        w_adv_nxt    = 1'b0;
        w_held_nxt   = r_key_held;
        case (r_state)
            ST_SCAN: begin
                if (r_dwell == DWELL_LAST) begin
                    w_dwell_nxt = {DW_W{1'b0}};
                end else begin
                    w_dwell_nxt = r_dwell + DW_W'(1);
                end
                if (w_sample && w_row_ok) begin
                    w_row_nxt    = w_row_idx;
                    w_col_nxt    = w_col_idx;
                    w_stable_nxt = {ST_W{1'b0}};
                    w_state_nxt  = ST_DEBOUNCE;
                end else if ((r_dwell == DWELL_LAST) && (r_scols == 4'h0)) begin
                    w_adv_nxt = 1'b1;
                end else begin
                    w_adv_nxt = 1'b0;
                end
            end
            ST_DEBOUNCE: begin
                if (!w_tracked) begin
                    w_dwell_nxt = {DW_W{1'b0}};
                    w_state_nxt = ST_SCAN;
                end else if (r_stable == STABLE_LAST) begin
                    w_code_nxt   = {r_row, r_col};
                    w_valid_nxt  = 1'b1;
                    w_held_nxt   = 1'b1;
                    w_stable_nxt = {ST_W{1'b0}};
                    w_state_nxt  = ST_HELD;
                end else begin
                    w_stable_nxt = r_stable + ST_W'(1);
                end
            end
            ST_HELD: begin
                if (!w_tracked) begin
                    w_stable_nxt = {ST_W{1'b0}};
                    w_state_nxt  = ST_RELEASE;
                end else begin
                    w_state_nxt = ST_HELD;
                end
            end
            ST_RELEASE: begin
                if (w_tracked) begin
                    w_stable_nxt = {ST_W{1'b0}};
                    w_state_nxt  = ST_HELD;
                end else if (r_stable == STABLE_LAST) begin
                    w_held_nxt   = 1'b0;
                    w_stable_nxt = {ST_W{1'b0}};
                    w_dwell_nxt  = {DW_W{1'b0}};
                    w_state_nxt  = ST_SCAN;
                end else begin
                    w_stable_nxt = r_stable + ST_W'(1);
                end
            end
            default: begin
                w_stable_nxt = {ST_W{1'b0}};
                w_dwell_nxt  = {DW_W{1'b0}};
                w_held_nxt   = 1'b0;
                w_state_nxt  = ST_SCAN;
            end
        endcase
    end

    // State, synchronizer and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_SCAN;
            r_sync1     <= 4'h0;
            r_scols     <= 4'h0;
            r_dwell     <= {DW_W{1'b0}};
            r_stable    <= {ST_W{1'b0}};
            r_row       <= 2'd0;
            r_col       <= 2'd0;
            r_key_code  <= 4'h0;
            r_key_valid <= 1'b0;
            r_advance   <= 1'b0;
            r_key_held  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_sync1     <= cols;
            r_scols     <= r_sync1;
            r_dwell     <= w_dwell_nxt;
            r_stable    <= w_stable_nxt;
            r_row       <= w_row_nxt;
            r_col       <= w_col_nxt;
            r_key_code  <= w_code_nxt;
            r_key_valid <= w_valid_nxt;
            r_advance   <= w_adv_nxt;
            r_key_held  <= w_held_nxt;
        end
    end

    assign advance   = r_advance;
    assign key_code  = r_key_code;
    assign key_valid = r_key_valid;
    assign key_held  = r_key_held;

endmodule

// File: tb/tb_keypad_debounce_decode.sv
// Directed bench for keypad_debounce_decode with DB_CYCLES=8, SCAN_DIV=4.
module tb_keypad_debounce_decode;

    logic       clk;
    logic       reset;
    logic [3:0] cols;
    logic [3:0] rows;
    logic       advance;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    int n_cmp;
    int n_mis;
    int n_adv;
    int n_val;
    int n_adv_held;
    logic [3:0] last_code;

    keypad_debounce_decode #(
        .DB_CYCLES(8),
        .SCAN_DIV (4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .cols     (cols),
        .rows     (rows),
        .advance  (advance),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_held (key_held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (obs !== exp) begin
            n_mis = n_mis + 1;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance n clock edges, sampling outputs 1 ns after each edge.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            n_adv = n_adv + int'(advance);
            n_val = n_val + int'(key_valid);
            if (key_valid) last_code = key_code;
            if (key_held && advance) n_adv_held = n_adv_held + 1;
        end
    endtask

    task automatic clear_counts();
        n_adv      = 0;
        n_val      = 0;
        n_adv_held = 0;
        last_code  = 4'h0;
    endtask

    initial begin
        n_cmp = 0;
        n_mis = 0;
        clear_counts();
        reset = 1'b1;
        cols  = 4'h0;
        rows  = 4'b0001;

        // reset state
        step(2);
        check_eq("rst_advance", advance, 1'b0);
        check_eq("rst_valid", key_valid, 1'b0);
        check_eq("rst_held", key_held, 1'b0);
        check_eq("rst_code", key_code, 4'h0);

        // idle scanning: one advance every 4 cycles
        reset = 1'b0;
        clear_counts();
        step(16);
        check_eq("idle_adv_count", n_adv, 4);
        check_eq("idle_adv_last", advance, 1'b1);
        check_eq("idle_valid", n_val, 0);

        // row 2 col 1 held for 30 cycles -> code 9
        rows = 4'b0100;
        cols = 4'b0010;
        clear_counts();
        step(30);
        check_eq("p9_valid_cnt", n_val, 1);
        check_eq("p9_code", last_code, 4'h9);
        check_eq("p9_held", key_held, 1'b1);
        check_eq("p9_adv_held", n_adv_held, 0);
        check_eq("p9_adv_now", advance, 1'b0);
        cols = 4'h0;
        step(15);
        check_eq("p9_rel_held", key_held, 1'b0);
        check_eq("p9_rel_code", key_code, 4'h9);
        clear_counts();
        step(8);
        check_eq("p9_resume_adv", n_adv, 2);
        check_eq("p9_resume_val", n_val, 0);

        // short press of 5 cycles is rejected
        rows = 4'b0001;
        cols = 4'b0001;
        clear_counts();
        step(5);
        cols = 4'h0;
        step(12);
        check_eq("short_valid", n_val, 0);
        check_eq("short_held", key_held, 1'b0);
        check_eq("short_code", key_code, 4'h9);
        clear_counts();
        step(8);
        check_eq("short_resume_adv", n_adv, 2);

        // rows not one-hot: capture ignored, no advance while columns active
        rows = 4'b0110;
        cols = 4'b0001;
        step(4);
        clear_counts();
        step(16);
        check_eq("nonhot_valid", n_val, 0);
        check_eq("nonhot_adv", n_adv, 0);
        check_eq("nonhot_held", key_held, 1'b0);
        cols = 4'h0;
        rows = 4'b0001;
        step(4);

        // bounce during release: single key, exact release timing
        rows = 4'b1000;
        cols = 4'b0001;
        clear_counts();
        step(20);
        check_eq("bnc_code", last_code, 4'hC);
        cols = 4'h0;
        step(3);
        check_eq("bnc_held_lo", key_held, 1'b1);
        cols = 4'b0001;
        step(5);
        check_eq("bnc_held_re", key_held, 1'b1);
        cols = 4'h0;
        step(10);
        check_eq("bnc_held_pre", key_held, 1'b1);
        step(1);
        check_eq("bnc_held_fall", key_held, 1'b0);
        check_eq("bnc_valid_cnt", n_val, 1);
        check_eq("bnc_code_keep", key_code, 4'hC);
        clear_counts();
        step(8);
        check_eq("bnc_resume_adv", n_adv, 2);

        // multiple columns: lowest wins
        rows = 4'b0001;
        cols = 4'b1010;
        clear_counts();
        step(20);
        check_eq("multi_valid_cnt", n_val, 1);
        check_eq("multi_code", key_code, 4'h1);
        cols = 4'h0;
        step(14);
        check_eq("multi_rel_held", key_held, 1'b0);

        // reset during debounce
        rows = 4'b0010;
        cols = 4'b0100;
        clear_counts();
        step(8);
        check_eq("rdb_pre_valid", n_val, 0);
        reset = 1'b1;
        cols  = 4'h0;
        step(1);
        check_eq("rdb_held", key_held, 1'b0);
        check_eq("rdb_valid", key_valid, 1'b0);
        check_eq("rdb_adv", advance, 1'b0);
        check_eq("rdb_code", key_code, 4'h0);
        reset = 1'b0;
        clear_counts();
        step(8);
        check_eq("rdb_resume_adv", n_adv, 2);
        check_eq("rdb_resume_val", n_val, 0);

        // reset during held
        cols = 4'b0100;
        clear_counts();
        step(20);
        check_eq("rhd_pre_valid", n_val, 1);
        check_eq("rhd_pre_code", key_code, 4'h6);
        reset = 1'b1;
        cols  = 4'h0;
        step(1);
        check_eq("rhd_held", key_held, 1'b0);
        check_eq("rhd_valid", key_valid, 1'b0);
        check_eq("rhd_adv", advance, 1'b0);
        check_eq("rhd_code", key_code, 4'h0);
        reset = 1'b0;
        clear_counts();
        step(8);
        check_eq("rhd_resume_adv", n_adv, 2);
        check_eq("rhd_resume_val", n_val, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
